alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Parametrised, registered successor to the 64-bit ripple ALU in the LegV8 datapath.
//   Executes AND/ORR/EOR/NOR/ADD/SUB/PASS-B in one cycle and an iterative MUL over several cycles.
//   Uses valid/ready handshakes on input and output, and produces full NZCV flags (overflow implemented).
//   Sits between the register-read stage and the memory/writeback stage; zero feeds CBZ/CBNZ.
// PARAMETERS
//   WIDTH     64  operand/result width; 8..64; must be a multiple of MUL_STEP
//   MUL_STEP  1   multiplier bits retired per MUL cycle (1, 2 or 4)
// PORTS
//   clock      in   1              rising-edge clock
//   reset      in   1              asynchronous, active-high reset
//   in_valid   in   1              op/a/b/shamt valid
//   in_ready   out  1              block can accept an op this cycle
//   op         in   4              0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 PASS-B, 0011 EOR,
//                                  1100 NOR, 1000 MUL, 1001 LSL*, 1010 LSR*  (*macro only)
//   a          in   WIDTH          operand A
//   b          in   WIDTH          operand B
//   shamt      in   $clog2(WIDTH)  shift amount (LSL/LSR only)
//   out_valid  out  1              result/flags valid
//   out_ready  in   1              consumer takes result this cycle
//   result     out  WIDTH          registered result
//   zero       out  1              result == 0
//   negative   out  1              result[WIDTH-1]
//   carry      out  1              unsigned carry-out (ADD/SUB only, else 0)
//   overflow   out  1              signed overflow on ADD/SUB; nonzero upper product half on MUL
//   busy       out  1              FSM in MUL
// BEHAVIOUR
//   Reset: FSM=IDLE; result=0; out_valid=0; zero=0; negative=carry=overflow=0; busy=0.
//   Reset is honoured at any time and aborts an in-flight MUL with no output.
//   Accept: in_valid && in_ready.
//     in_ready = (state==IDLE) && (!out_valid || out_ready).
//     This is a single-entry output buffer; drain and accept in the same cycle are allowed.
//   FSM states:
//     IDLE: single-cycle op accepted -> result/flags registered, out_valid=1 next edge, stay IDLE.
//           MUL accepted -> latch a, b; clear 2*WIDTH accumulator; go to MUL.
//     MUL:  add (a << i) * b[i +: MUL_STEP] per cycle for WIDTH/MUL_STEP cycles.
//           On the last step, write result=acc[WIDTH-1:0] and out_valid=1, then go to IDLE.
//   Latency: single-cycle ops = 1 clock to out_valid; MUL = WIDTH/MUL_STEP + 1 clocks from accept.
//   Output hold: while out_valid && !out_ready, result and flags are stable.
//     out_valid drops the cycle after a take with no new completion.
//   SUB = a + ~b + 1.
//     carry = cout[WIDTH-1] (1 means no borrow).
//     overflow = cin[WIDTH-1] ^ cout[WIDTH-1].
//   ADD wraps modulo 2^WIDTH; carry = cout[WIDTH-1].
//   PASS-B: result=b, C=V=0 (CBZ tests zero).
//   MUL: unsigned low-half result; carry=0; overflow = |acc[2*WIDTH-1:WIDTH].
//   Illegal/unsupported op: single cycle, result=0, zero=1, N=C=V=0.
//   Inputs are ignored when not accepted; a and b may change freely during MUL.
// CONFIGURATION
//   ALU_SHIFT_EN defined:
//     op 1001 LSL -> result = a << shamt; op 1010 LSR -> result = a >> shamt (logical).
//     Both are single cycle; C=V=0.
//   ALU_SHIFT_EN undefined:
//     1001 and 1010 are illegal (result=0, zero=1); shamt is unused.
// TESTING
//   1 Reset during MUL (WIDTH=64, 5 cycles in) -> out_valid=0, busy=0, in_ready=1 after release; no result.
//   2 ADD a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> result=64'h8000_0000_0000_0000, N=1, V=1, C=0, Z=0, 1 cycle.
//   3 SUB a=5, b=5 -> result=0, Z=1, C=1, V=0.
//     SUB a=0, b=1 -> result=all-ones, N=1, C=0.
//   4 MUL a=64'h1_0000_0000, b=64'h1_0000_0000 -> result=0, Z=1, V=1, out_valid 65 cycles after accept.
//     MUL_STEP=4, a=6, b=7 -> result=42, 17 cycles after accept.
//   5 Backpressure: out_ready=0 for 3 cycles after AND a=F0, b=3C -> result=30 held, in_ready=0.
//     out_ready=1 with a new op offered -> take and accept occur on the same edge.
//   6 ALU_SHIFT_EN: LSL a=1, shamt=63 -> result=64'h8000_0000_0000_0000, N=1.
//     Without the macro: same stimulus -> result=0, Z=1.

Source files
------------

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : registered LegV8 ALU with valid/ready handshakes.
//   Single-cycle AND/ORR/EOR/NOR/ADD/SUB/PASS-B. MUL is an iterative
//   shift-and-add that retires MUL_STEP multiplier bits per cycle.
//   Produces full NZCV flags. The zero flag feeds CBZ/CBNZ.
//
//   Optional feature: define ALU_SHIFT_EN to enable LSL (1001) and LSR (1010).
//   Without it, those opcodes are illegal and return result=0, zero=1.
//
// Ports
//   clock, reset        rising-edge clock, async active-high reset
//   in_valid/in_ready   operation handshake (op, a, b, shamt)
//   out_valid/out_ready result handshake (single-entry output buffer)
//   result              registered WIDTH-bit result
//   zero/negative/carry/overflow  registered NZCV flags
//   busy                high while a MUL is iterating
//
// Parameters
//   WIDTH     operand width, 8..64, a multiple of MUL_STEP
//   MUL_STEP  multiplier bits retired per MUL cycle (1, 2 or 4)
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned MUL_STEP = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               op,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic [$clog2(WIDTH)-1:0] shamt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         result,
   output logic                     zero,
   output logic                     negative,
   output logic                     carry,
   output logic                     overflow,
   output logic                     busy
);

   localparam int unsigned W2    = 2 * WIDTH;
   localparam int unsigned WP1   = WIDTH + 1;
   localparam int unsigned STEPS = WIDTH / MUL_STEP;
   localparam int unsigned CNT_W = $clog2(STEPS);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_ORR  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_EOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_SHIFT_EN
   localparam logic [3:0] OP_LSL  = 4'b1001;
   localparam logic [3:0] OP_LSR  = 4'b1010;
`else
   // shamt only matters when the shifter is built in
   logic unused_shamt;
   assign unused_shamt = ^shamt;
`endif

   logic [0:0]       state, state_next;
   logic [W2-1:0]    mcand, mcand_next;
   logic [WIDTH-1:0] mplier, mplier_next;
   logic [W2-1:0]    acc, acc_next;
   logic [CNT_W-1:0] cnt, cnt_next;

   logic [WIDTH-1:0] result_next;
   logic             zero_next, negative_next, carry_next, overflow_next;
   logic             out_valid_next, busy_next;

   logic [WIDTH-1:0] add_b, alu_res;
   logic [WIDTH:0]   add_sum;
   logic             is_sub, alu_c, alu_v;
   logic [W2-1:0]    partial, acc_sum;
   logic             mul_last;

   // Single-entry output buffer: accept only when idle and the slot is free or draining
   assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
   assign mul_last = (cnt == CNT_W'(STEPS - 1));

   // Single-cycle datapath; SUB is a + ~b + 1 so carry=1 means no borrow
   always_comb begin
      is_sub  = (op == OP_SUB);
      add_b   = is_sub ? ~b : b;
      add_sum = {1'b0, a} + {1'b0, add_b} + WP1'(is_sub);
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_AND:  alu_res = a & b;
         OP_ORR:  alu_res = a | b;
         OP_EOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_PASS: alu_res = b;
         OP_ADD, OP_SUB: begin
            alu_res = add_sum[WIDTH-1:0];
            alu_c   = add_sum[WIDTH];
            // same-sign operands producing an opposite-sign sum
            alu_v   = (a[WIDTH-1] == add_b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
`ifdef ALU_SHIFT_EN
         OP_LSL:  alu_res = a << shamt;
         OP_LSR:  alu_res = a >> shamt;
`endif
         default: alu_res = '0;
      endcase
   end

   // One MUL iteration: add the multiplicand shifted by each set bit of the current digit
   always_comb begin
      partial = '0;
      for (int unsigned j = 0; j < MUL_STEP; j++) begin
         if (mplier[j]) partial = partial + (mcand << j);
      end
      acc_sum = acc + partial;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_next     = state;
      mcand_next     = mcand;
      mplier_next    = mplier;
      acc_next       = acc;
      cnt_next       = cnt;
      result_next    = result;
      zero_next      = zero;
      negative_next  = negative;
      carry_next     = carry;
      overflow_next  = overflow;
      out_valid_next = out_valid;

      if (out_valid && out_ready) out_valid_next = 1'b0;

      case (state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               if (op == OP_MUL) begin
                  mcand_next  = W2'(a);
                  mplier_next = b;
                  acc_next    = '0;
                  cnt_next    = '0;
                  state_next  = S_MUL;
               end else begin
                  result_next    = alu_res;
                  zero_next      = (alu_res == '0);
                  negative_next  = alu_res[WIDTH-1];
                  carry_next     = alu_c;
                  overflow_next  = alu_v;
                  out_valid_next = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_next    = acc_sum;
            mcand_next  = mcand << MUL_STEP;
            mplier_next = mplier >> MUL_STEP;
            cnt_next    = cnt + CNT_W'(1);
            if (mul_last) begin
               result_next    = acc_sum[WIDTH-1:0];
               zero_next      = (acc_sum[WIDTH-1:0] == '0);
               negative_next  = acc_sum[WIDTH-1];
               carry_next     = 1'b0;
               overflow_next  = |acc_sum[W2-1:WIDTH];
               out_valid_next = 1'b1;
               state_next     = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      busy_next = (state_next == S_MUL);
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         result    <= '0;
         zero      <= 1'b0;
         negative  <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         mcand     <= mcand_next;
         mplier    <= mplier_next;
         acc       <= acc_next;
         cnt       <= cnt_next;
         result    <= result_next;
         zero      <= zero_next;
         negative  <= negative_next;
         carry     <= carry_next;
         overflow  <= overflow_next;
         out_valid <= out_valid_next;
         busy      <= busy_next;
      end
   end

endmodule
